// File: rtl/serial_frame_rx_if.sv
// Output handshake bundle for serial_frame_rx.
// master drives data_out/data_valid; slave drives data_ready.
interface serial_frame_rx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              data_ready;

   modport master (
      output data_out,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_out,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start(1), DATA_W bits LSB first, even parity, stop(0).
// Ports: clk, Rst (async low), bit_en, serial_in, m_rx (data_out/valid/ready),
//   parity_err, frame_err, overrun (1-cycle pulses), frame_cnt, busy.
module serial_frame_rx #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             bit_en,
   input  logic             serial_in,
   serial_frame_rx_if.master m_rx,
   output logic             parity_err,
   output logic             frame_err,
   output logic             overrun,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             busy
);

   localparam int BCW = $clog2(DATA_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PAR,
      S_STOP
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] r_data;
   logic [BCW-1:0]    r_cnt;
   logic [CNT_W-1:0]  r_fcnt;
   logic              r_par;
   logic              r_valid;
   logic              r_perr;
   logic              r_ferr;
   logic              r_ovr;

   logic w_start;
   logic w_shift;
   logic w_latch_p;
   logic w_eval;
   logic w_last;
   logic w_par_bad;
   logic w_slot_free;
   logic w_load;

   assign w_last      = (r_cnt == BCW'(DATA_W - 1));
   assign w_par_bad   = ^{r_shift, r_par};
   // Slot is reusable when the consumer takes the old word on this same edge.
   assign w_slot_free = !r_valid || m_rx.data_ready;
   assign w_load      = w_eval && !serial_in && !w_par_bad && w_slot_free;

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (bit_en) begin
         unique case (r_state)
            S_IDLE: if (serial_in) w_next = S_DATA;
            S_DATA: if (w_last) w_next = S_PAR;
            S_PAR:  w_next = S_STOP;
            S_STOP: w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = (r_state != S_IDLE);
      w_start   = 1'b0;
      w_shift   = 1'b0;
      w_latch_p = 1'b0;
      w_eval    = 1'b0;
      if (bit_en) begin
         unique case (r_state)
            S_IDLE: w_start   = serial_in;
            S_DATA: w_shift   = 1'b1;
            S_PAR:  w_latch_p = 1'b1;
            S_STOP: w_eval    = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_par   <= 1'b0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_fcnt  <= '0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_perr <= 1'b0;
         r_ferr <= 1'b0;
         r_ovr  <= 1'b0;
         if (w_start) begin
            r_cnt <= '0;
         end
         // LSB arrives first, so shifting in at the top leaves it at bit 0.
         if (w_shift) begin
            r_shift <= {serial_in, r_shift[DATA_W-1:1]};
            r_cnt   <= r_cnt + 1'b1;
         end
         if (w_latch_p) begin
            r_par <= serial_in;
         end
         if (w_eval) begin
            if (serial_in) begin
               r_ferr <= 1'b1;
            end else if (w_par_bad) begin
               r_perr <= 1'b1;
            end else if (!w_slot_free) begin
               r_ovr <= 1'b1;
            end
         end
         if (w_load) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
            r_fcnt  <= r_fcnt + 1'b1;
         end else if (r_valid && m_rx.data_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign m_rx.data_out   = r_data;
   assign m_rx.data_valid = r_valid;
   assign parity_err      = r_perr;
   assign frame_err       = r_ferr;
   assign overrun         = r_ovr;
   assign frame_cnt       = r_fcnt;

endmodule
